// File: rtl/multi_blinker.sv
// Multi-channel programmable blinker: per-channel power-of-two blink rate,
// adjusted one channel at a time by edge-detected shift buttons.
module multi_blinker #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned CH_W       = 2,
  parameter int unsigned RATE_W     = 3,
  parameter int unsigned BASE_LOG2  = 4,
  parameter int unsigned RESET_RATE = 3,
  parameter int unsigned FLASH      = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CH_W-1:0]            ch_sel,
  input  logic                       shift_left,
  input  logic                       shift_right,
  input  logic [CHANNELS-1:0]        enable,
  output logic [CHANNELS-1:0]        out,
  output logic [CHANNELS*RATE_W-1:0] rate
);

  localparam int unsigned CNT_W = BASE_LOG2 + (1 << RATE_W) - 1;
  localparam logic [RATE_W-1:0] RATE_MAX  = '1;
  localparam logic [RATE_W-1:0] RATE_INIT = RATE_W'(RESET_RATE);

  logic                               prev_l_q, prev_r_q;
  logic [CHANNELS-1:0][RATE_W-1:0]    rate_q, rate_d;
  logic [CHANNELS-1:0][CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHANNELS-1:0][CNT_W-1:0]     cnt_last;
  logic [CHANNELS-1:0]                out_q, out_d;
  logic [CHANNELS-1:0]                restart;
  logic                               rise_l, rise_r, sel_valid;

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_l_q <= 1'b0;
      prev_r_q <= 1'b0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        rate_q[c] <= RATE_INIT;
      end
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      prev_l_q <= shift_left;
      prev_r_q <= shift_right;
      rate_q   <= rate_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
    end
  end

  // Button steps, restart, and per-channel counter/output next state
  always_comb begin
    rise_l    = shift_left & ~prev_l_q;
    rise_r    = shift_right & ~prev_r_q;
    sel_valid = 32'(ch_sel) < CHANNELS;
    rate_d    = rate_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    restart   = '0;
    cnt_last  = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      // H-1 as a low-bit mask; a shift of the full width yields all ones
      cnt_last[c] = ~({CNT_W{1'b1}} << (BASE_LOG2 + 32'(rate_q[c])));
      if (sel_valid && (ch_sel == CH_W'(c))) begin
        if (rise_l && !rise_r && (rate_q[c] != RATE_MAX)) begin
          rate_d[c]  = rate_q[c] + RATE_W'(1);
          restart[c] = 1'b1;
        end else if (rise_r && !rise_l && (rate_q[c] != '0)) begin
          rate_d[c]  = rate_q[c] - RATE_W'(1);
          restart[c] = 1'b1;
        end
      end
      if (restart[c] || !enable[c]) begin
        cnt_d[c] = '0;
        out_d[c] = 1'b0;
      end else if (cnt_q[c] == cnt_last[c]) begin
        cnt_d[c] = '0;
        out_d[c] = (FLASH != 0) ? ~out_q[c] : 1'b1;
      end else begin
        cnt_d[c] = cnt_q[c] + CNT_W'(1);
        out_d[c] = (FLASH != 0) ? out_q[c] : 1'b0;
      end
    end
  end

  assign out  = out_q;
  assign rate = rate_q;

endmodule

// File: tb/tb_multi_blinker.sv
// Directed bench for multi_blinker: square-wave and pulse instances share stimulus;
// expected outputs come from an edge-count/phase-anchor model of each channel.
module tb_multi_blinker;

  logic       clk;
  logic       rst;
  logic [1:0] ch_sel;
  logic       shift_left;
  logic       shift_right;
  logic [2:0] enable;
  logic [2:0] out_f, out_p;
  logic [5:0] rate_f, rate_p;

  multi_blinker #(.CHANNELS(3), .CH_W(2), .RATE_W(2), .BASE_LOG2(1),
                  .RESET_RATE(1), .FLASH(1)) dut_flash (
    .clk(clk), .rst(rst), .ch_sel(ch_sel), .shift_left(shift_left),
    .shift_right(shift_right), .enable(enable), .out(out_f), .rate(rate_f));

  multi_blinker #(.CHANNELS(3), .CH_W(2), .RATE_W(2), .BASE_LOG2(1),
                  .RESET_RATE(1), .FLASH(0)) dut_pulse (
    .clk(clk), .rst(rst), .ch_sel(ch_sel), .shift_left(shift_left),
    .shift_right(shift_right), .enable(enable), .out(out_p), .rate(rate_p));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard
  string       tag_q[$];
  logic [31:0] exp_q[$];

  // Model: edges counted since start, per-channel anchor edge (cnt=0, out=0 after it)
  int         k = 0;
  int         anchor[3];
  int         rate_m[3];
  logic [2:0] en_m;

  function automatic logic [2:0] exp_flash();
    logic [2:0] v = '0;
    for (int c = 0; c < 3; c++) begin
      int h = 1 << (1 + rate_m[c]);
      if (en_m[c] && (((k - anchor[c]) / h) % 2 == 1)) v[c] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [2:0] exp_pulse();
    logic [2:0] v = '0;
    for (int c = 0; c < 3; c++) begin
      int h = 1 << (1 + rate_m[c]);
      if (en_m[c] && (k - anchor[c] > 0) && ((k - anchor[c]) % h == 0)) v[c] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [5:0] exp_rate();
    return {2'(rate_m[2]), 2'(rate_m[1]), 2'(rate_m[0])};
  endfunction

  task automatic push(input string t, input logic [31:0] e);
    tag_q.push_back(t);
    exp_q.push_back(e);
  endtask

  task automatic check_pop(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0h expected nothing", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", t, obs, e);
      end
    end
  endtask

  // One clock edge with all outputs checked against the model
  task automatic step_edge(input string name);
    k++;
    for (int c = 0; c < 3; c++) if (!en_m[c]) anchor[c] = k;
    push($sformatf("%s flash_out k=%0d", name, k), 32'(exp_flash()));
    push($sformatf("%s pulse_out k=%0d", name, k), 32'(exp_pulse()));
    push($sformatf("%s flash_rate k=%0d", name, k), 32'(exp_rate()));
    push($sformatf("%s pulse_rate k=%0d", name, k), 32'(exp_rate()));
    @(posedge clk);
    @(negedge clk);
    check_pop(32'(out_f));
    check_pop(32'(out_p));
    check_pop(32'(rate_f));
    check_pop(32'(rate_p));
  endtask

  // Reset-state check, no clock edge involved
  task automatic check_reset_state(input string name);
    push({name, " flash_out"}, 32'(3'b000));
    push({name, " pulse_out"}, 32'(3'b000));
    push({name, " flash_rate"}, 32'(6'b01_01_01));
    push({name, " pulse_rate"}, 32'(6'b01_01_01));
    check_pop(32'(out_f));
    check_pop(32'(out_p));
    check_pop(32'(rate_f));
    check_pop(32'(rate_p));
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      anchor[c] = k;
      rate_m[c] = 1;
    end
  endtask

  initial begin
    rst = 1'b0; ch_sel = '0; shift_left = 1'b0; shift_right = 1'b0; enable = '0;
    en_m = '0;
    for (int c = 0; c < 3; c++) begin anchor[c] = 0; rate_m[c] = 1; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("power_on_reset");

    // Button held through release counts as a rise on the first edge
    release_reset();
    enable = 3'b111; en_m = 3'b111;
    ch_sel = 2'd0; shift_left = 1'b1;
    rate_m[0] = 2; anchor[0] = k + 1;
    step_edge("held_at_release");
    shift_left = 1'b0;
    repeat (3) step_edge("pre_reset_run");

    // Scenario 1: asynchronous reset mid-cycle while outputs are high
    #2 rst = 1'b0;
    #1 check_reset_state("async_reset");
    repeat (2) @(posedge clk);
    release_reset();
    repeat (20) step_edge("free_run");

    // Scenario 2: three left steps on channel 1, last one saturates
    ch_sel = 2'd1; shift_left = 1'b1;
    rate_m[1] = 2; anchor[1] = k + 1;
    step_edge("ch1_step1");
    shift_left = 1'b0;
    step_edge("ch1_gap1");
    shift_left = 1'b1;
    rate_m[1] = 3; anchor[1] = k + 1;
    step_edge("ch1_step2");
    shift_left = 1'b0;
    step_edge("ch1_gap2");
    shift_left = 1'b1;
    step_edge("ch1_saturate");
    shift_left = 1'b0;
    repeat (16) step_edge("ch1_slow_run");

    // Scenario 3: held right button on channel 0, then simultaneous rises
    ch_sel = 2'd0; shift_right = 1'b1;
    rate_m[0] = 0; anchor[0] = k + 1;
    repeat (10) step_edge("ch0_hold_right");
    shift_right = 1'b0;
    step_edge("ch0_release");
    shift_left = 1'b1; shift_right = 1'b1;
    repeat (3) step_edge("both_rise");
    shift_left = 1'b0; shift_right = 1'b0;
    step_edge("both_release");
    shift_left = 1'b1;
    rate_m[0] = 1; anchor[0] = k + 1;
    repeat (4) step_edge("ch0_hold_left");
    shift_left = 1'b0;
    step_edge("ch0_left_release");

    // Scenario 4: out-of-range channel select
    ch_sel = 2'd3; shift_left = 1'b1;
    step_edge("invalid_sel");
    shift_left = 1'b0;
    repeat (7) step_edge("invalid_sel_run");

    // Scenario 5: enable gating on channel 2 while its output is high
    enable = 3'b011; en_m = 3'b011;
    repeat (3) step_edge("ch2_disabled");
    enable = 3'b111; en_m = 3'b111;
    repeat (8) step_edge("ch2_reenabled");

    // Scenario 6: reset while the pulse instance has a pulse on channel 2
    #2 rst = 1'b0;
    #1 check_reset_state("reset_mid_pulse");
    repeat (2) @(posedge clk);
    release_reset();
    repeat (8) step_edge("post_reset_run");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_blinker.md
# multi_blinker

Parametrised multi-channel programmable blinker, the successor to the single-channel programmable blinker. It drives `CHANNELS` independent LED outputs, each with its own blink-rate exponent. The user adjusts one channel at a time with `ch_sel` and edge-detected `shift_left` and `shift_right` buttons. It sits between the debounced button inputs and the board LEDs.

## Interface
- `CHANNELS`, 4: number of blink channels (1..16).
- `CH_W`, 2: width of `ch_sel`. Must be at least clog2(`CHANNELS`) and at least 1.
- `RATE_W`, 3: width of each rate exponent. The rate range is 0..2^`RATE_W`-1.
- `BASE_LOG2`, 4: log2 of the half-period at rate 0.
- `RESET_RATE`, 3: rate loaded into every channel on reset.
- `FLASH`, 1: selects the output mode.
  - 1: square wave.
  - 0: single-cycle pulse.
- `clk` in 1: the single clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `ch_sel` in `CH_W`: channel targeted by the shift buttons.
- `shift_left` in 1: button level. A rising edge increments the selected channel's rate, doubling its period.
- `shift_right` in 1: button level. A rising edge decrements the selected channel's rate, halving its period.
- `enable` in `CHANNELS`: per-channel run enable.
- `out` out `CHANNELS`: blink outputs.
- `rate` out `CHANNELS`*`RATE_W`: current rate per channel. Channel c occupies bits [c*`RATE_W` +: `RATE_W`].

## Operation
- Half-period of channel c: H[c] = 2^(`BASE_LOG2` + rate[c]) cycles.
  - Counter width CNT_W = `BASE_LOG2` + 2^`RATE_W` - 1.
  - Comparisons are done at full CNT_W width; there is no truncation.
- Edge detect: `shift_left` and `shift_right` are each registered once (prev_l, prev_r).
  - A rise is detected when the input = 1 and its prev = 0.
  - Holding a button high gives exactly one step.
- Step rules, applied to channel `ch_sel`:
  - Left rise only: rate += 1, saturating at 2^`RATE_W`-1.
  - Right rise only: rate -= 1, saturating at 0.
  - Both rises in the same cycle: no change.
  - `ch_sel` ≥ `CHANNELS`: no change to any channel.
- Restart on rate change: when a step actually changes rate[c], the same edge clears cnt[c] and out[c] to 0.
  - A saturated step (value unchanged) does not restart the channel.
- Per channel, when `enable`[c] = 0: cnt[c] is forced to 0 and out[c] to 0. The rate is still adjustable.
- Per channel, when `enable`[c] = 1 and no restart occurs:
  - cnt[c] counts 0..H[c]-1, then wraps to 0.
  - `FLASH`=1: out[c] toggles at the edge where cnt[c] = H[c]-1, giving a square wave of period 2·H[c].
  - `FLASH`=0: out[c] is 1 for exactly the one cycle following the edge where cnt[c] = H[c]-1, and 0 otherwise. Pulse period is H[c].
- Channels are fully independent. Stepping one channel never disturbs the counter or output of another.

## Timing
- On reset assertion (`rst`=0, asynchronous, no clock needed):
  - `out` = 0.
  - Every rate field = `RESET_RATE`.
  - All counters = 0.
  - prev_l = prev_r = 0.
- After reset deassertion, a button already held high is treated as a rise on the first clock edge.
- Step latency: the `rate` output and the restart take effect at the same edge that samples the rising level. They are visible one cycle after the button rises.
- `ch_sel` is sampled at that same edge.
- First `FLASH`=1 toggle after enable rises (or after a restart): out goes high at the H[c]-th edge counted from the first enabled edge.
- Deasserting `enable`[c] clears out[c] at the next edge.
- Reset asserted mid-count or mid-pulse: all outputs drop to 0 immediately. No partial pulse is completed.
- Outputs are registered. There is no combinational path from any input to `out` or `rate`.

## Test plan
All scenarios use bench parameters `CHANNELS`=3, `CH_W`=2, `RATE_W`=2, `BASE_LOG2`=1, `RESET_RATE`=1, `FLASH`=1, so H = 4 at reset.

1. **Reset and free run.** Pulse `rst` low mid-cycle, then set `enable`=3'b111.
   - `out`=0 and every rate field = 1 immediately while `rst` is low.
   - After release, each out toggles every 4 cycles (period 8), all channels in phase.
2. **Step and saturate.** `ch_sel`=1, three separate `shift_left` pulses.
   - rate[1] goes 2 → 3 → 3.
   - The first two steps clear out[1] and cnt[1]. The third step changes nothing.
   - Final half-period of channel 1 is 16 cycles; channels 0 and 2 are unaffected.
3. **Hold and simultaneous edges.**
   - Hold `shift_right` high for 10 cycles on channel 0: exactly one step, rate[0] 1 → 0, H = 2.
   - Raise both buttons in the same cycle: no rate change and no restart.
4. **Invalid select.** `ch_sel`=3 with a `shift_left` pulse: no rate changes and no output disturbance on any channel.
5. **Enable gating.**
   - Drop `enable`[2] mid-period: out[2] = 0 at the next edge.
   - Re-enable: the first toggle comes exactly 4 edges later.
6. **Pulse mode.** Rerun scenario 1 with `FLASH`=0.
   - Each out is high for exactly 1 cycle every 4 cycles.
   - Asserting `rst` during a pulse clears it immediately.
